freq_smoother: RTL and testbench

- Sits between the gated frequency counter and the sheet-count threshold decoder in the paper-count meter.
- Takes one frequency count per 1 s gate (pulse-qualified) and produces an 8-sample moving average plus a "stable" flag.
- The decoder uses the average, so single noisy gates no longer flip the displayed sheet count.
- Runs on the 6 MHz system clock.

---
 rtl/freq_smoother.sv | 261 ++++++++++++++++++++++++++
 tb/tb_freq_smoother.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_smoother.sv
// -----------------------------------------------------------------------------
// freq_smoother
//
// Purpose:
//   Moving-average filter for the paper-count meter. It sits between the gated
//   frequency counter and the sheet-count threshold decoder. Each 1 s gate
//   delivers one frequency count. The block keeps an 8-sample circular window
//   and outputs its running mean, together with a "stable" flag. With this
//   filter, a single noisy gate no longer flips the displayed sheet count.
//
//   Pipeline: stage 1 writes the sample and updates the running sum. Stage 2
//   computes the average and the stability state. Latency from freq_vld to
//   avg_vld is 2 cycles, and a new sample may be accepted every cycle.
//
//   While the window is still filling (FILL), freq_avg passes the latest sample
//   straight through. Once 8 samples are held (RUN), freq_avg is sum/8.
//
// Optional feature (macro FREQ_SMOOTHER_OUTLIER_EN):
//   In RUN, a sample that differs from freq_avg by more than OUTLIER_TOL is
//   discarded, and outlier_rej pulses. The 4th outlier in a row flushes the
//   window and restarts it with that sample, so a genuine step change is
//   tracked. Without the macro, outlier_rej is constant 0.
//
// Ports:
//   clk_6M       in   6 MHz system clock
//   reset_n      in   asynchronous active-low reset
//   freq_in      in   [DATA_W]       frequency count of the completed gate
//   freq_vld     in   strobe, freq_in valid (back-to-back allowed)
//   clear        in   synchronous flush of the window
//   freq_avg     out  [DATA_W]       filtered frequency
//   avg_vld      out  strobe, freq_avg updated
//   stable       out  filtered value has settled
//   fill_cnt     out  [DEPTH_LOG2+1] samples currently held (0..8)
//   outlier_rej  out  strobe, sample discarded
// -----------------------------------------------------------------------------
module freq_smoother #(
    parameter int DATA_W      = 28,
    parameter int DEPTH_LOG2  = 3,
    parameter int STABLE_TOL  = 2000,
    parameter int STABLE_N    = 3,
    parameter int OUTLIER_TOL = 20000
) (
    input  logic                  clk_6M,
    input  logic                  reset_n,
    input  logic [DATA_W-1:0]     freq_in,
    input  logic                  freq_vld,
    input  logic                  clear,
    output logic [DATA_W-1:0]     freq_avg,
    output logic                  avg_vld,
    output logic                  stable,
    output logic [DEPTH_LOG2:0]   fill_cnt,
    output logic                  outlier_rej
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int SUM_W  = DATA_W + DEPTH_LOG2;
    localparam int STAB_W = $clog2(STABLE_N + 1);

`ifdef FREQ_SMOOTHER_OUTLIER_EN
    localparam bit OUTLIER_EN = 1'b1;
`else
    localparam bit OUTLIER_EN = 1'b0;
`endif

    localparam logic [DEPTH_LOG2:0] FILL_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [STAB_W-1:0]   STAB_MAX   = STAB_W'(STABLE_N);
    localparam logic [DATA_W:0]     STAB_LIM   = (DATA_W + 1)'(STABLE_TOL);
    localparam logic [DATA_W:0]     OUTL_LIM   = (DATA_W + 1)'(OUTLIER_TOL);
    localparam logic [1:0]          OUTL_FLUSH = 2'd3;  // 3 rejected, 4th flushes

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Unsigned absolute difference. One extra bit keeps the subtraction from
    // wrapping.
    function automatic logic [DATA_W:0] abs_diff(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [DATA_W:0] ax;
        logic [DATA_W:0] bx;
        ax = {1'b0, a};
        bx = {1'b0, b};
        return (ax >= bx) ? (ax - bx) : (bx - ax);
    endfunction

    // ------------------------------------------------------------------ state
    state_e                 state_q,       state_d;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q,      wr_ptr_d;
    logic [SUM_W-1:0]       sum_q,         sum_d;
    logic [DEPTH_LOG2:0]    fill_cnt_q,    fill_cnt_d;
    logic [STAB_W-1:0]      stab_cnt_q,    stab_cnt_d;
    logic [DATA_W-1:0]      freq_avg_q,    freq_avg_d;   // also serves as prev_avg
    logic                   avg_vld_q,     avg_vld_d;
    logic                   stable_q,      stable_d;
    logic                   outlier_rej_q, outlier_rej_d;
    logic [1:0]             outl_cnt_q,    outl_cnt_d;
    logic                   s2_vld_q,      s2_vld_d;     // stage-2 result pending
    logic [DATA_W-1:0]      s2_sample_q,   s2_sample_d;  // sample for FILL pass-through

    logic [DATA_W-1:0]      mem [DEPTH];
    logic                   mem_we;
    logic [DEPTH_LOG2-1:0]  mem_waddr;

    // ------------------------------------------------------ datapath helpers
    logic [SUM_W-1:0]       sum_acc;
    logic [DATA_W-1:0]      avg_new;
    logic                   avg_steady;
    logic                   is_outlier;

    // In RUN, the oldest sample leaves the window. That is the entry about to
    // be overwritten.
    assign sum_acc    = sum_q + SUM_W'(freq_in)
                        - ((state_q == ST_RUN) ? SUM_W'(mem[wr_ptr_q]) : '0);
    assign avg_new    = (state_q == ST_RUN) ? DATA_W'(sum_q >> DEPTH_LOG2)
                                            : s2_sample_q;
    assign avg_steady = (abs_diff(avg_new, freq_avg_q) <= STAB_LIM);
    assign is_outlier = OUTLIER_EN && (state_q == ST_RUN)
                        && (abs_diff(freq_in, freq_avg_q) > OUTL_LIM);

    // ------------------------------------------------------ next-state logic
    // NOTE: every variable gets a default at the top of the block. This keeps
    // the block purely combinational, so no latch is inferred on any path.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        sum_d         = sum_q;
        fill_cnt_d    = fill_cnt_q;
        stab_cnt_d    = stab_cnt_q;
        freq_avg_d    = freq_avg_q;
        avg_vld_d     = 1'b0;
        stable_d      = stable_q;
        outlier_rej_d = 1'b0;
        outl_cnt_d    = outl_cnt_q;
        s2_vld_d      = 1'b0;
        s2_sample_d   = s2_sample_q;
        mem_we        = 1'b0;
        mem_waddr     = wr_ptr_q;

        // Stage 2: publish the average and update the stability tracking.
        if (s2_vld_q) begin
            avg_vld_d  = 1'b1;
            freq_avg_d = avg_new;
            if (avg_steady) begin
                stab_cnt_d = (stab_cnt_q == STAB_MAX) ? STAB_MAX
                                                      : stab_cnt_q + 1'b1;
            end else begin
                stab_cnt_d = '0;
            end
            stable_d = (state_q == ST_RUN) && (stab_cnt_d == STAB_MAX);
        end

        // Stage 1: accept, reject or restart on the incoming sample.
        if (freq_vld) begin
            if (is_outlier && (outl_cnt_q != OUTL_FLUSH)) begin
                outlier_rej_d = 1'b1;
                stab_cnt_d    = '0;
                stable_d      = 1'b0;
                outl_cnt_d    = outl_cnt_q + 1'b1;
            end else if (is_outlier) begin
                // Persistent outlier: treat it as a real step. Flush the
                // window (any pending average is dropped, as on clear) and
                // restart with this sample as the first FILL entry.
                avg_vld_d   = 1'b0;
                freq_avg_d  = freq_avg_q;
                mem_we      = 1'b1;
                mem_waddr   = '0;
                wr_ptr_d    = DEPTH_LOG2'(1);
                sum_d       = SUM_W'(freq_in);
                fill_cnt_d  = (DEPTH_LOG2 + 1)'(1);
                state_d     = ST_FILL;
                stab_cnt_d  = '0;
                stable_d    = 1'b0;
                outl_cnt_d  = '0;
                s2_vld_d    = 1'b1;
                s2_sample_d = freq_in;
            end else begin
                mem_we      = 1'b1;
                wr_ptr_d    = wr_ptr_q + 1'b1;
                sum_d       = sum_acc;
                outl_cnt_d  = '0;
                s2_vld_d    = 1'b1;
                s2_sample_d = freq_in;
                if (fill_cnt_q != FILL_FULL) begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
                if ((state_q == ST_FILL) && (fill_cnt_q == FILL_FULL - 1'b1)) begin
                    state_d = ST_RUN;
                end
            end
        end

        // clear overrides everything. It drops the incoming sample and any
        // pending average, and freq_avg keeps its last value.
        if (clear) begin
            state_d       = ST_FILL;
            wr_ptr_d      = '0;
            sum_d         = '0;
            fill_cnt_d    = '0;
            stab_cnt_d    = '0;
            stable_d      = 1'b0;
            freq_avg_d    = freq_avg_q;
            avg_vld_d     = 1'b0;
            outlier_rej_d = 1'b0;
            outl_cnt_d    = '0;
            s2_vld_d      = 1'b0;
            mem_we        = 1'b0;
        end
    end

    // ------------------------------------------------------------- registers
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the clock edge, regardless of
    // statement order.
    always_ff @(posedge clk_6M or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_FILL;
            wr_ptr_q      <= '0;
            sum_q         <= '0;
            fill_cnt_q    <= '0;
            stab_cnt_q    <= '0;
            freq_avg_q    <= '0;
            avg_vld_q     <= 1'b0;
            stable_q      <= 1'b0;
            outlier_rej_q <= 1'b0;
            outl_cnt_q    <= '0;
            s2_vld_q      <= 1'b0;
            s2_sample_q   <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            sum_q         <= sum_d;
            fill_cnt_q    <= fill_cnt_d;
            stab_cnt_q    <= stab_cnt_d;
            freq_avg_q    <= freq_avg_d;
            avg_vld_q     <= avg_vld_d;
            stable_q      <= stable_d;
            outlier_rej_q <= outlier_rej_d;
            outl_cnt_q    <= outl_cnt_d;
            s2_vld_q      <= s2_vld_d;
            s2_sample_q   <= s2_sample_d;
        end
    end

    // NOTE: the sample RAM has no reset. Its contents are never read before
    // being written, because in FILL the sum ignores the outgoing entry. This
    // lets it map onto plain RAM.
    always_ff @(posedge clk_6M) begin
        if (mem_we) begin
            mem[mem_waddr] <= freq_in;
        end
    end

    // --------------------------------------------------------------- outputs
    assign freq_avg    = freq_avg_q;
    assign avg_vld     = avg_vld_q;
    assign stable      = stable_q;
    assign fill_cnt    = fill_cnt_q;
    assign outlier_rej = outlier_rej_q;

endmodule

// File: tb/tb_freq_smoother.sv
// -----------------------------------------------------------------------------
// tb_freq_smoother
//
// Directed testbench for freq_smoother. Inputs are driven, and outputs
// sampled, on the falling clock edge. Expected values are hand-computed
// constants. The outlier scenarios are included when FREQ_SMOOTHER_OUTLIER_EN
// is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_freq_smoother;

    localparam int DATA_W     = 28;
    localparam int DEPTH_LOG2 = 3;

    logic                 clk_6M;
    logic                 reset_n;
    logic [DATA_W-1:0]    freq_in;
    logic                 freq_vld;
    logic                 clear;
    logic [DATA_W-1:0]    freq_avg;
    logic                 avg_vld;
    logic                 stable;
    logic [DEPTH_LOG2:0]  fill_cnt;
    logic                 outlier_rej;

    int n_tests = 0;
    int n_fail  = 0;

    freq_smoother #(
        .DATA_W      (DATA_W),
        .DEPTH_LOG2  (DEPTH_LOG2),
        .STABLE_TOL  (2000),
        .STABLE_N    (3),
        .OUTLIER_TOL (20000)
    ) dut (
        .clk_6M      (clk_6M),
        .reset_n     (reset_n),
        .freq_in     (freq_in),
        .freq_vld    (freq_vld),
        .clear       (clear),
        .freq_avg    (freq_avg),
        .avg_vld     (avg_vld),
        .stable      (stable),
        .fill_cnt    (fill_cnt),
        .outlier_rej (outlier_rej)
    );

    initial clk_6M = 1'b0;
    always #83.333 clk_6M = ~clk_6M;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One sample, then check the stage-1 and stage-2 outputs at their cycles.
    task automatic send_chk(input logic [DATA_W-1:0] v, input int exp_avg,
                            input int exp_fill, input logic exp_stable,
                            input string tag);
        @(negedge clk_6M);
        freq_in  = v;
        freq_vld = 1'b1;
        @(negedge clk_6M);
        freq_vld = 1'b0;
        check({tag, "/fill"},  32'(fill_cnt), 32'(exp_fill));
        check({tag, "/early"}, 32'(avg_vld),  32'd0);
        @(negedge clk_6M);
        check({tag, "/vld"},    32'(avg_vld),  32'd1);
        check({tag, "/avg"},    32'(freq_avg), 32'(exp_avg));
        check({tag, "/stable"}, 32'(stable),   32'(exp_stable));
    endtask

    // A sample that the outlier filter must discard.
    task automatic send_rej(input logic [DATA_W-1:0] v, input int exp_avg,
                            input string tag);
        @(negedge clk_6M);
        freq_in  = v;
        freq_vld = 1'b1;
        @(negedge clk_6M);
        freq_vld = 1'b0;
        check({tag, "/rej"},  32'(outlier_rej), 32'd1);
        check({tag, "/fill"}, 32'(fill_cnt),    32'd8);
        @(negedge clk_6M);
        check({tag, "/novld"}, 32'(avg_vld),  32'd0);
        check({tag, "/avg"},   32'(freq_avg), 32'(exp_avg));
    endtask

    initial begin
        int exp_b2b [8];
        exp_b2b = '{1, 2, 3, 4, 5, 6, 7, 4};

        reset_n  = 1'b0;
        freq_in  = '0;
        freq_vld = 1'b0;
        clear    = 1'b0;

        // ---- reset state
        repeat (3) @(negedge clk_6M);
        check("rst/avg",    32'(freq_avg),    32'd0);
        check("rst/vld",    32'(avg_vld),     32'd0);
        check("rst/stable", 32'(stable),      32'd0);
        check("rst/fill",   32'(fill_cnt),    32'd0);
        check("rst/rej",    32'(outlier_rej), 32'd0);
        reset_n = 1'b1;
        @(negedge clk_6M);

        // ---- 8 x 100000: pass-through in FILL, stable rises on the 8th
        for (int i = 0; i < 8; i++)
            send_chk(28'd100000, 100000, i + 1, (i == 7), "fill100k");

        // ---- 11 x 200000: ramp by 12500 per sample, stable again on the 19th
        for (int i = 0; i < 11; i++)
            send_chk(28'd200000, (i < 8) ? 112500 + 12500 * i : 200000, 8,
                     (i == 10), "step200k");

        // ---- plain clear: window flushed, freq_avg held
        @(negedge clk_6M);
        clear = 1'b1;
        @(negedge clk_6M);
        clear = 1'b0;
        check("clr/fill",   32'(fill_cnt), 32'd0);
        check("clr/stable", 32'(stable),   32'd0);
        check("clr/vld",    32'(avg_vld),  32'd0);
        check("clr/avg",    32'(freq_avg), 32'd200000);

        // ---- back-to-back 1..8: eight consecutive avg_vld, last is floor(36/8)
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_6M);
            if (c >= 2) begin
                check("b2b/vld", 32'(avg_vld),  32'd1);
                check("b2b/avg", 32'(freq_avg), 32'(exp_b2b[c-2]));
            end
            if (c < 8) begin
                freq_in  = DATA_W'(c + 1);
                freq_vld = 1'b1;
            end else begin
                freq_vld = 1'b0;
            end
        end
        @(negedge clk_6M);
        check("b2b/idle",   32'(avg_vld),  32'd0);
        check("b2b/fill",   32'(fill_cnt), 32'd8);
        check("b2b/stable", 32'(stable),   32'd1);

        // ---- clear together with freq_vld after 5 samples
        @(negedge clk_6M);
        clear = 1'b1;
        @(negedge clk_6M);
        clear = 1'b0;
        for (int i = 0; i < 5; i++)
            send_chk(28'd5000, 5000, i + 1, 1'b0, "five");
        @(negedge clk_6M);
        freq_in  = 28'd9999;
        freq_vld = 1'b1;
        clear    = 1'b1;
        @(negedge clk_6M);
        freq_vld = 1'b0;
        clear    = 1'b0;
        check("clrvld/fill",   32'(fill_cnt), 32'd0);
        check("clrvld/stable", 32'(stable),   32'd0);
        check("clrvld/vld1",   32'(avg_vld),  32'd0);
        @(negedge clk_6M);
        check("clrvld/vld2",   32'(avg_vld),  32'd0);
        check("clrvld/avg",    32'(freq_avg), 32'd5000);

        // ---- clear while a stage-2 result is pending
        @(negedge clk_6M);
        freq_in  = 28'd7000;
        freq_vld = 1'b1;
        @(negedge clk_6M);
        freq_vld = 1'b0;
        clear    = 1'b1;
        check("clrpend/fill1", 32'(fill_cnt), 32'd1);
        @(negedge clk_6M);
        clear = 1'b0;
        check("clrpend/vld",   32'(avg_vld),  32'd0);
        check("clrpend/avg",   32'(freq_avg), 32'd5000);
        check("clrpend/fill0", 32'(fill_cnt), 32'd0);

        // ---- reset between freq_vld and avg_vld
        for (int i = 0; i < 8; i++)
            send_chk(28'd50000, 50000, i + 1, (i == 7), "fill50k");
        @(negedge clk_6M);
        freq_in  = 28'd60000;
        freq_vld = 1'b1;
        @(negedge clk_6M);
        freq_vld = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("rstmid/avg",    32'(freq_avg),    32'd0);
        check("rstmid/vld",    32'(avg_vld),     32'd0);
        check("rstmid/stable", 32'(stable),      32'd0);
        check("rstmid/fill",   32'(fill_cnt),    32'd0);
        check("rstmid/rej",    32'(outlier_rej), 32'd0);
        @(negedge clk_6M);
        reset_n = 1'b1;
        check("rstmid/vld2", 32'(avg_vld), 32'd0);
        @(negedge clk_6M);
        check("rstmid/vld3", 32'(avg_vld), 32'd0);
        send_chk(28'd42, 42, 1, 1'b0, "rstfirst");

`ifdef FREQ_SMOOTHER_OUTLIER_EN
        // ---- outlier rejection and step tracking
        @(negedge clk_6M);
        clear = 1'b1;
        @(negedge clk_6M);
        clear = 1'b0;
        for (int i = 0; i < 8; i++)
            send_chk(28'd100000, 100000, i + 1, (i == 7), "out/fill");
        send_rej(28'd300000, 100000, "out/single");
        send_chk(28'd100000, 100000, 8, 1'b0, "out/accept");
        for (int i = 0; i < 3; i++)
            send_rej(28'd300000, 100000, "out/run");
        @(negedge clk_6M);
        freq_in  = 28'd300000;
        freq_vld = 1'b1;
        @(negedge clk_6M);
        freq_vld = 1'b0;
        check("out/4th/rej",  32'(outlier_rej), 32'd0);
        check("out/4th/fill", 32'(fill_cnt),    32'd1);
        @(negedge clk_6M);
        check("out/4th/vld",  32'(avg_vld),  32'd1);
        check("out/4th/avg",  32'(freq_avg), 32'd300000);
`else
        // ---- without the outlier feature a large jump is simply averaged
        @(negedge clk_6M);
        clear = 1'b1;
        @(negedge clk_6M);
        clear = 1'b0;
        for (int i = 0; i < 8; i++)
            send_chk(28'd100000, 100000, i + 1, (i == 7), "noout/fill");
        @(negedge clk_6M);
        freq_in  = 28'd300000;
        freq_vld = 1'b1;
        @(negedge clk_6M);
        freq_vld = 1'b0;
        check("noout/rej", 32'(outlier_rej), 32'd0);
        @(negedge clk_6M);
        check("noout/vld", 32'(avg_vld),  32'd1);
        check("noout/avg", 32'(freq_avg), 32'd125000);
`endif

        repeat (2) @(negedge clk_6M);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
